// File: rtl/clyde_tweak_sched.sv
// rtl/clyde_tweak_sched.sv - Clyde-128 tweak schedule sequencer driving an external phi_dual
// Emits NSTEPS+1 tweak values per run over a valid/ready stream; all stream outputs are registered.
module clyde_tweak_sched #(
    parameter int NSTEPS = 6,
    parameter int CW     = 3
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          start,
    input  logic          decrypt,
    input  logic [127:0]  tweak_in,
    output logic [127:0]  phi_in,
    output logic          phi_inverse,
    input  logic [127:0]  phi_out,
    output logic          tk_valid,
    input  logic          tk_ready,
    output logic [127:0]  tweak_out,
    output logic [CW-1:0] tk_step,
    output logic          tk_last,
    output logic          busy,
    output logic          done
);

    localparam logic [CW-1:0] LAST_STEP = CW'(NSTEPS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [127:0]    r_tweak;
    logic            r_mode;
    logic [CW-1:0]   r_step;
    logic            r_valid;
    logic            r_last;
    logic            r_busy;
    logic            r_done;
    logic [CW-1:0]   w_step_nx;

    assign w_step_nx = r_step + 1'b1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_tweak <= '0;
            r_mode  <= 1'b0;
            r_step  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_tweak <= tweak_in;
                        r_mode  <= decrypt;
                        r_step  <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_last  <= (LAST_STEP == '0);
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (tk_ready) begin
                        if (r_step != LAST_STEP) begin
                            // phi_out is derived from r_tweak/r_mode, so this is the next schedule value
                            r_tweak <= phi_out;
                            r_step  <= w_step_nx;
                            r_last  <= (w_step_nx == LAST_STEP);
                        end else begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign phi_in      = r_tweak;
    assign phi_inverse = r_mode;
    assign tweak_out   = r_tweak;
    assign tk_step     = r_step;
    assign tk_valid    = r_valid;
    assign tk_last     = r_last;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_clyde_tweak_sched.sv
// tb/tb_clyde_tweak_sched.sv - randomized self-checking bench for clyde_tweak_sched
// A behavioural phi_dual sits beside the DUT; expected sequences come from iterating phi.
module tb_clyde_tweak_sched;

    localparam int NSTEPS = 6;
    localparam int CW     = 3;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          start = 1'b0;
    logic          decrypt = 1'b0;
    logic [127:0]  tweak_in = '0;
    logic          tk_ready = 1'b0;
    logic [127:0]  phi_in;
    logic          phi_inverse;
    logic [127:0]  phi_out;
    logic          tk_valid;
    logic [127:0]  tweak_out;
    logic [CW-1:0] tk_step;
    logic          tk_last;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] exp_q [0:NSTEPS];

    clyde_tweak_sched #(.NSTEPS(NSTEPS), .CW(CW)) u_dut (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start),
        .decrypt     (decrypt),
        .tweak_in    (tweak_in),
        .phi_in      (phi_in),
        .phi_inverse (phi_inverse),
        .phi_out     (phi_out),
        .tk_valid    (tk_valid),
        .tk_ready    (tk_ready),
        .tweak_out   (tweak_out),
        .tk_step     (tk_step),
        .tk_last     (tk_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // (t0,t1) -> (t0^t1, t0), t0 = low word
    function automatic logic [127:0] phi_fwd(input logic [127:0] x);
        return {x[63:0], x[63:0] ^ x[127:64]};
    endfunction

    function automatic logic [127:0] phi_inv(input logic [127:0] x);
        return {x[63:0] ^ x[127:64], x[127:64]};
    endfunction

    assign phi_out = phi_inverse ? phi_inv(phi_in) : phi_fwd(phi_in);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic build(input logic [127:0] t, input logic dec);
        exp_q[0] = t;
        for (int s = 1; s <= NSTEPS; s++)
            exp_q[s] = dec ? phi_inv(exp_q[s-1]) : phi_fwd(exp_q[s-1]);
    endtask

    task automatic launch(input logic [127:0] t, input logic dec);
        start    = 1'b1;
        tweak_in = t;
        decrypt  = dec;
    endtask

    // Entered #1 after an edge with start already driven; ends #1 after the cycle following DONE.
    task automatic run_body(input logic dec, input bit rnd_ready, input bit inj,
                            input bit chain, input logic [127:0] tn, input logic dn);
        int idx = 0;
        int cyc = 0;
        bit xfer;
        @(posedge clk); #1;
        start = 1'b0;
        chk("valid_latency", tk_valid, 1'b1);
        chk("busy_run", busy, 1'b1);
        while (idx <= NSTEPS && cyc < 300) begin
            chk("step", tk_step, idx);
            chk("tweak", tweak_out, exp_q[idx]);
            chk("phi_in", phi_in, exp_q[idx]);
            chk("last", tk_last, idx == NSTEPS);
            chk("valid", tk_valid, 1'b1);
            chk("phi_inverse", phi_inverse, dec);
            chk("busy", busy, 1'b1);
            chk("done_low", done, 1'b0);
            tk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inj && idx == 2) begin
                start    = 1'b1;
                tweak_in = {$urandom, $urandom, $urandom, $urandom};
                decrypt  = ~dec;
            end else begin
                start = 1'b0;
            end
            xfer = tk_ready;
            @(posedge clk); #1;
            if (xfer) idx++;
            cyc++;
        end
        start    = 1'b0;
        tk_ready = 1'b0;
        chk("transfers", idx, NSTEPS + 1);
        chk("done_pulse", done, 1'b1);
        chk("valid_in_done", tk_valid, 1'b0);
        chk("busy_in_done", busy, 1'b0);
        chk("last_in_done", tk_last, 1'b0);
        if (chain) launch(tn, dn);
        @(posedge clk); #1;
        chk("done_cleared", done, 1'b0);
        chk("busy_idle", busy, 1'b0);
        chk("valid_idle", tk_valid, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, tk_valid, 1'b0);
        chk({tag, "_last"}, tk_last, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_tweak"}, tweak_out, 128'h0);
        chk({tag, "_step"}, tk_step, 3'd0);
        chk({tag, "_inverse"}, phi_inverse, 1'b0);
    endtask

    initial begin
        logic [127:0] t;
        logic [127:0] t2;
        logic         d;
        logic         d2;
        int           cyc;

        #2;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk); #1;

        t = {64'h2, 64'h1};
        exp_q[0] = t;             exp_q[1] = {64'h1, 64'h3}; exp_q[2] = {64'h3, 64'h2};
        exp_q[3] = t;             exp_q[4] = {64'h1, 64'h3}; exp_q[5] = {64'h3, 64'h2};
        exp_q[6] = t;
        launch(t, 1'b0);
        run_body(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        exp_q[1] = {64'h3, 64'h2}; exp_q[2] = {64'h1, 64'h3};
        exp_q[4] = {64'h3, 64'h2}; exp_q[5] = {64'h1, 64'h3};
        launch(t, 1'b1);
        run_body(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        build(t, 1'b0);
        launch(t, 1'b0);
        run_body(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);

        t = {$urandom, $urandom, $urandom, $urandom};
        build(t, 1'b1);
        launch(t, 1'b1);
        run_body(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);

        t = {$urandom, $urandom, $urandom, $urandom};
        launch(t, 1'b1);
        tk_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (tk_step != 3'd3 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reach_step3", tk_step, 3'd3);
        tk_ready = 1'b0;
        nrst = 1'b0;
        #1;
        chk_zero("midrun_reset");
        @(posedge clk); #1;
        chk("no_done_after_reset", done, 1'b0);
        nrst = 1'b1;
        @(posedge clk); #1;
        chk("no_done_idle", done, 1'b0);
        t = {$urandom, $urandom, $urandom, $urandom};
        build(t, 1'b0);
        launch(t, 1'b0);
        run_body(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);

        t  = {$urandom, $urandom, $urandom, $urandom};
        t2 = {$urandom, $urandom, $urandom, $urandom};
        d  = 1'($urandom_range(0, 1));
        d2 = ~d;
        build(t, d);
        launch(t, d);
        run_body(d, 1'b1, 1'b0, 1'b1, t2, d2);
        build(t2, d2);
        run_body(d2, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            t = {$urandom, $urandom, $urandom, $urandom};
            d = 1'($urandom_range(0, 1));
            build(t, d);
            launch(t, d);
            run_body(d, 1'b1, r[0], 1'b0, '0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clyde_tweak_sched.md
Name: clyde_tweak_sched

Overview:
Sequencer for the Clyde-128 tweak schedule. It holds the public 128-bit tweak, drives an external phi_dual instance (forward for encryption, inverse for decryption), and streams one tweak value per step boundary to the round datapath through a valid/ready handshake. Masked key shares are XORed downstream; this block handles only the unmasked tweak.

Parameters:
NSTEPS, 6, number of Clyde steps; the block emits NSTEPS+1 tweak values per run.
CW, 3, width of the step counter; must satisfy 2^CW > NSTEPS.

Ports:
clk  input  1  system clock, rising edge.
nrst  input  1  asynchronous active-low reset.
start  input  1  run request, accepted only when busy=0.
decrypt  input  1  mode, sampled with start: 0 = forward phi, 1 = inverse phi.
tweak_in  input  128  initial tweak T, sampled with start.
phi_in  output  128  to phi_dual.phi_in; equals tweak register.
phi_inverse  output  1  to phi_dual.inverse; equals the latched mode.
phi_out  input  128  from phi_dual.phi_out.
tk_valid  output  1  tweak_out holds the current step's tweak.
tk_ready  input  1  consumer accepts tweak_out.
tweak_out  output  128  current tweak value.
tk_step  output  CW  index 0..NSTEPS of the value on tweak_out.
tk_last  output  1  high with tk_valid when tk_step==NSTEPS.
busy  output  1  run in progress.
done  output  1  one-cycle pulse after the last tweak is accepted.

Behaviour:
- Reset (nrst=0, async): state IDLE; tweak register=0; mode=0; step=0. tk_valid=0, tk_last=0, busy=0, done=0, tweak_out=0, tk_step=0.
- States: IDLE, EMIT, DONE.
- IDLE: busy=0. On start=1, latch tweak_in into the tweak register, latch decrypt into mode, clear step to 0, and move to EMIT on the next edge. start while busy=1 is ignored, with no effect on the latched mode or tweak.
- EMIT: tk_valid=1 and busy=1.
  - tweak_out = tweak register; tk_step = step.
  - tk_valid rises the cycle after start, giving 1-cycle start-to-valid latency.
- Transfer occurs when tk_valid & tk_ready:
  - If step<NSTEPS: tweak register <= phi_out; step <= step+1; remain in EMIT. A back-to-back transfer is possible every cycle.
  - If step==NSTEPS: go to DONE; the tweak register is unchanged.
- tk_valid=1 and tweak_out stay stable until transfer. Holding tk_ready=0 for any number of cycles must not change state.
- DONE: a single cycle with done=1, busy=0 and tk_valid=0, then IDLE. A start asserted in DONE is ignored.
- phi_in and phi_inverse are driven continuously from the registers, so phi_out is combinational from registered values. No combinational path from tk_ready to tweak_out.
- Sequence semantics with phi the forward map (t0,t1)->(t0^t1, t0), with t0 the low 64 bits:
  - Encryption emits T, phi(T), phi^2(T), T, ... The period is 3, so step s carries phi^(s mod 3)(T).
  - Decryption emits T, phi^-1(T), phi^-2(T), ... This equals the encryption sequence reversed, because NSTEPS mod 3 = 0 for the default.
- tk_last = tk_valid & (step==NSTEPS).
- Reset asserted mid-run: immediate return to the reset values. No done pulse; a partial sequence is discarded.
- Step counter never exceeds NSTEPS and never wraps.

Test Plan:
- Encrypt, T = {64'h0000000000000002, 64'h0000000000000001}, tk_ready=1:
  - tk_valid high 1 cycle after start; 7 consecutive transfers.
  - tweak_out sequence is T, {1,3}, {3,2}, T, {1,3}, {3,2}, T (high word listed first).
  - tk_last high only on step 6; done pulses the cycle after.
- Decrypt, same T: sequence T, {3,2}, {1,3}, T, {3,2}, {1,3}, T; phi_inverse=1 throughout.
- Backpressure: tk_ready toggled pseudo-randomly while tk_valid is stalled.
  - tweak_out/tk_step stay stable during stalls; exactly 7 transfers; values match the encrypt case.
- start pulsed during EMIT with a different tweak_in and decrypt:
  - Ignored; the sequence is unchanged and mode stays as latched.
- nrst pulsed low at step 3:
  - All outputs 0 immediately; no done pulse.
  - A new start afterwards restarts at step 0 with the new tweak.
- Back-to-back runs: start asserted the cycle after done.
  - Second run accepted; busy=0 only during the DONE and IDLE cycles.
